store_monitor: RTL and testbench

STORE_MONITOR -- requirements
Module: store_monitor

---
 rtl/store_monitor.sv | 163 ++++++++++++++++
 tb/tb_store_monitor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_monitor.sv
// Store monitor: arms on start, matches core stores against an in-order expected-store table
// and reports pass / fail / timeout. Define STORE_MON_RETIRE_EN to enable the retire counter.
module store_monitor #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned TIMEOUT = 100000,
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned LEN_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tbl_we,
   input  logic [IDX_W-1:0]  tbl_idx,
   input  logic [ADDR_W-1:0] tbl_addr,
   input  logic [DATA_W-1:0] tbl_data,
   input  logic [LEN_W-1:0]  tbl_len,
   input  logic [ADDR_W-1:0] fail_addr,
   input  logic              start,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              retire,
   output logic              busy,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [LEN_W-1:0]  match_idx,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [CNT_W-1:0]  retire_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_PASS,
      S_FAIL,
      S_TMO
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            tbl_q [DEPTH];
   entry_t            tbl_d [DEPTH];
   entry_t            cur_entry;
   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [LEN_W-1:0]  match_idx_q, match_idx_d;
   logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
   logic              busy_q, busy_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic              timeout_q, timeout_d;
   logic              start_ok;
   logic              store_match;

`ifndef STORE_MON_RETIRE_EN
   logic unused_retire;
   assign unused_retire = retire;
`endif

   // Table is frozen while a run is armed so the expected sequence cannot shift under it.
   always_comb begin
      tbl_d = tbl_q;
      if (tbl_we && (state_q != S_ARMED)) begin
         tbl_d[tbl_idx] = '{addr: tbl_addr, data: tbl_data};
      end
   end

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      fail_addr_d  = fail_addr_q;
      match_idx_d  = match_idx_q;
      cycle_cnt_d  = cycle_cnt_q;
      retire_cnt_d = retire_cnt_q;

      cur_entry   = tbl_q[match_idx_q[IDX_W-1:0]];
      store_match = mem_write && (mem_addr == cur_entry.addr) && (mem_wdata == cur_entry.data);
      start_ok    = start && (tbl_len != '0) && (tbl_len <= LEN_W'(DEPTH));

      if (state_q == S_ARMED) begin
         if (cycle_cnt_q != '1) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
         end
`ifdef STORE_MON_RETIRE_EN
         if (retire && (retire_cnt_q != '1)) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
         end
`endif
         // Priority: in-order match (possibly completing the run) > fail store > timeout.
         if (store_match) begin
            match_idx_d = match_idx_q + LEN_W'(1);
            if (match_idx_d == len_q) begin
               state_d = S_PASS;
            end
         end else if (mem_write && (mem_addr == fail_addr_q)) begin
            state_d = S_FAIL;
         end else if (cycle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d     = S_TMO;
            cycle_cnt_d = cycle_cnt_q;
         end
      end else if (start_ok) begin
         state_d      = S_ARMED;
         len_d        = tbl_len;
         fail_addr_d  = fail_addr;
         match_idx_d  = '0;
         cycle_cnt_d  = '0;
         retire_cnt_d = '0;
      end

      busy_d    = (state_d == S_ARMED);
      pass_d    = (state_d == S_PASS);
      fail_d    = (state_d == S_FAIL);
      timeout_d = (state_d == S_TMO);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         fail_addr_q  <= '0;
         match_idx_q  <= '0;
         cycle_cnt_q  <= '0;
         retire_cnt_q <= '0;
         busy_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         fail_addr_q  <= fail_addr_d;
         match_idx_q  <= match_idx_d;
         cycle_cnt_q  <= cycle_cnt_d;
         retire_cnt_q <= retire_cnt_d;
         busy_q       <= busy_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         timeout_q    <= timeout_d;
      end
   end

   // Table contents survive reset.
   always_ff @(posedge clk) begin
      tbl_q <= tbl_d;
   end

   assign busy       = busy_q;
   assign pass       = pass_q;
   assign fail       = fail_q;
   assign timeout    = timeout_q;
   assign match_idx  = match_idx_q;
   assign cycle_cnt  = cycle_cnt_q;
   assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor: a vector table for in-order matching / fail / start rules,
// plus hand sequences for the 10-cycle pass, timeout, retire counting and mid-run reset.
module tb_store_monitor;

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 32;
   localparam int unsigned TMO   = 50;
   localparam int unsigned IW    = 2;
   localparam int unsigned LW    = 3;

   localparam int OP_WR  = 0;
   localparam int OP_ARM = 1;
   localparam int OP_ST  = 2;
   localparam int OP_NST = 3;

   localparam logic [3:0] E_I = 4'b0000;
   localparam logic [3:0] E_A = 4'b1000;
   localparam logic [3:0] E_P = 4'b0100;
   localparam logic [3:0] E_F = 4'b0010;
   localparam logic [3:0] E_T = 4'b0001;

`ifdef STORE_MON_RETIRE_EN
   localparam int EXP_RET = 37;
`else
   localparam int EXP_RET = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          tbl_we;
   logic [IW-1:0] tbl_idx;
   logic [AW-1:0] tbl_addr;
   logic [DW-1:0] tbl_data;
   logic [LW-1:0] tbl_len;
   logic [AW-1:0] fail_addr;
   logic          start;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          retire;
   logic          busy, pass, fail, timeout;
   logic [LW-1:0] match_idx;
   logic [CW-1:0] cycle_cnt, retire_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   store_monitor #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr),
      .tbl_data(tbl_data), .tbl_len(tbl_len), .fail_addr(fail_addr), .start(start),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .retire(retire),
      .busy(busy), .pass(pass), .fail(fail), .timeout(timeout), .match_idx(match_idx),
      .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
   );

   typedef struct {
      int          op;
      int          a;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  e_st;
      int          e_idx;
      int          e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int op, input int a, input logic [31:0] ad,
                               input logic [31:0] da, input logic [3:0] st,
                               input int idx, input int cnt);
      vec_t v;
      v.op = op; v.a = a; v.addr = ad; v.data = da;
      v.e_st = st; v.e_idx = idx; v.e_cnt = cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_data = '0;
      tbl_len = '0; fail_addr = '0; start = 1'b0;
      mem_write = 1'b0; mem_addr = '0; mem_wdata = '0; retire = 1'b0;
   endtask

   task automatic check_status(input string tag, input logic [3:0] st, input int idx, input int cnt);
      check({tag, " busy"},      32'(busy),      32'(st[3]));
      check({tag, " pass"},      32'(pass),      32'(st[2]));
      check({tag, " fail"},      32'(fail),      32'(st[1]));
      check({tag, " timeout"},   32'(timeout),   32'(st[0]));
      check({tag, " match_idx"}, 32'(match_idx), 32'(idx));
      check({tag, " cycle_cnt"}, cycle_cnt,      32'(cnt));
   endtask

   task automatic write_entry(input int idx, input logic [31:0] ad, input logic [31:0] da);
      tbl_we = 1'b1; tbl_idx = IW'(idx); tbl_addr = ad; tbl_data = da;
      tick();
      tbl_we = 1'b0;
   endtask

   task automatic arm(input int len, input logic [31:0] fa);
      start = 1'b1; tbl_len = LW'(len); fail_addr = fa;
      tick();
      start = 1'b0;
   endtask

   task automatic store(input logic [31:0] ad, input logic [31:0] da);
      mem_write = 1'b1; mem_addr = ad; mem_wdata = da;
      tick();
      mem_write = 1'b0;
   endtask

   initial begin
      vecs.push_back(mk(OP_WR,  0, 32'h100, 1,    E_I, 0, 0));
      vecs.push_back(mk(OP_WR,  1, 32'h104, 2,    E_I, 0, 0));
      vecs.push_back(mk(OP_ARM, 2, 32'hFFC, 0,    E_A, 0, 0));
      vecs.push_back(mk(OP_ST,  0, 32'h104, 2,    E_A, 0, 1));
      vecs.push_back(mk(OP_NST, 0, 32'h100, 1,    E_A, 0, 2));
      vecs.push_back(mk(OP_ST,  0, 32'h100, 1,    E_A, 1, 3));
      vecs.push_back(mk(OP_WR,  1, 32'h104, 99,   E_A, 1, 4));
      vecs.push_back(mk(OP_ST,  0, 32'h104, 2,    E_P, 2, 5));
      vecs.push_back(mk(OP_ST,  0, 32'h100, 1,    E_P, 2, 5));
      vecs.push_back(mk(OP_WR,  0, 32'h200, 7,    E_P, 2, 5));
      vecs.push_back(mk(OP_ARM, 1, 32'h4D4, 0,    E_A, 0, 0));
      vecs.push_back(mk(OP_ST,  0, 32'h300, 9,    E_A, 0, 1));
      vecs.push_back(mk(OP_ST,  0, 32'h4D4, 1234, E_F, 0, 2));
      vecs.push_back(mk(OP_ST,  0, 32'h200, 7,    E_F, 0, 2));
      vecs.push_back(mk(OP_ARM, 0, 32'h0,   0,    E_F, 0, 2));
      vecs.push_back(mk(OP_ARM, 5, 32'h0,   0,    E_F, 0, 2));
      vecs.push_back(mk(OP_WR,  0, 32'h4D4, 1234, E_F, 0, 2));
      vecs.push_back(mk(OP_ARM, 1, 32'h4D4, 0,    E_A, 0, 0));
      vecs.push_back(mk(OP_ARM, 1, 32'h4D4, 0,    E_A, 0, 1));
      vecs.push_back(mk(OP_ST,  0, 32'h4D4, 1234, E_P, 1, 2));
      vecs.push_back(mk(OP_WR,  2, 32'h10,  3,    E_P, 1, 2));
      vecs.push_back(mk(OP_WR,  3, 32'h14,  4,    E_P, 1, 2));
      vecs.push_back(mk(OP_WR,  0, 32'h8,   1,    E_P, 1, 2));
      vecs.push_back(mk(OP_WR,  1, 32'hC,   2,    E_P, 1, 2));
      vecs.push_back(mk(OP_ARM, 4, 32'hC,   0,    E_A, 0, 0));
      vecs.push_back(mk(OP_ST,  0, 32'h8,   1,    E_A, 1, 1));
      vecs.push_back(mk(OP_ST,  0, 32'hC,   2,    E_A, 2, 2));
      vecs.push_back(mk(OP_ST,  0, 32'h10,  3,    E_A, 3, 3));
      vecs.push_back(mk(OP_ST,  0, 32'h14,  4,    E_P, 4, 4));

      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      check_status("reset", E_I, 0, 0);
      check("reset retire_cnt", retire_cnt, 32'd0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         idle_inputs();
         case (vecs[i].op)
            OP_WR:  begin tbl_we = 1'b1; tbl_idx = IW'(vecs[i].a);
                          tbl_addr = vecs[i].addr; tbl_data = vecs[i].data; end
            OP_ARM: begin start = 1'b1; tbl_len = LW'(vecs[i].a); fail_addr = vecs[i].addr; end
            OP_ST:  begin mem_write = 1'b1; mem_addr = vecs[i].addr; mem_wdata = vecs[i].data; end
            default: begin mem_addr = vecs[i].addr; mem_wdata = vecs[i].data; end
         endcase
         tick();
         check_status($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_idx, vecs[i].e_cnt);
      end
      idle_inputs();

      // Expected store lands on the 10th armed cycle.
      write_entry(0, 32'h508, 2047);
      arm(1, 32'h0);
      for (int i = 1; i <= 9; i++) tick();
      check_status("pass10 before", E_A, 0, 9);
      store(32'h508, 2047);
      check_status("pass10", E_P, 1, 10);

      // No stores: timeout after TMO armed cycles with the counter frozen at TMO-1.
      arm(1, 32'h0);
      for (int i = 1; i <= 49; i++) tick();
      check_status("tmo before", E_A, 0, 49);
      tick();
      check_status("tmo", E_T, 0, 49);
      for (int i = 0; i < 3; i++) tick();
      check_status("tmo hold", E_T, 0, 49);

      // Retire on 37 armed cycles, then pass.
      arm(1, 32'h0);
      check("retire clear", retire_cnt, 32'd0);
      for (int i = 0; i < 40; i++) begin
         retire = (i < 37);
         tick();
      end
      retire = 1'b0;
      store(32'h508, 2047);
      check_status("retire pass", E_P, 1, 41);
      check("retire_cnt", retire_cnt, 32'(EXP_RET));
      retire = 1'b1;
      tick();
      retire = 1'b0;
      check("retire_cnt frozen", retire_cnt, 32'(EXP_RET));

      // Reset mid-run, then a clean restart.
      write_entry(0, 32'h100, 1);
      write_entry(1, 32'h104, 2);
      arm(2, 32'h0);
      store(32'h100, 1);
      check_status("prereset", E_A, 1, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check_status("midreset", E_I, 0, 0);
      check("midreset retire_cnt", retire_cnt, 32'd0);
      tick();
      check_status("postreset idle", E_I, 0, 0);
      arm(2, 32'h0);
      check_status("rearm", E_A, 0, 0);
      store(32'h100, 1);
      store(32'h104, 2);
      check_status("rerun pass", E_P, 2, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
